// File: rtl/snac_poll_scheduler_if.sv
// Button-word bus from the SNAC poll scheduler to the core input mapping.
// master = scheduler (drives), slave = input mapping (consumes).
interface snac_poll_scheduler_if #(
   parameter int NUM_BITS = 16
);
   // o_stb is a valid-only strobe with no ready: it is high for exactly one
   // clk_sys cycle when p1_btn/p2_btn/p*_absent take new values. The words
   // then hold until the next strobe, so the consumer may sample on o_stb or
   // read the held words at any later time.
   logic [NUM_BITS-1:0] p1_btn;
   logic [NUM_BITS-1:0] p2_btn;
   logic                o_stb;
   logic                busy;
   logic                p1_absent;
   logic                p2_absent;

   modport master (
      output p1_btn, p2_btn, o_stb, busy, p1_absent, p2_absent
   );

   modport slave (
      input p1_btn, p2_btn, o_stb, busy, p1_absent, p2_absent
   );
endinterface

// File: rtl/snac_poll_scheduler.sv
// SNAC controller poller: latch/shift-clock sequencing and capture of two 16-bit
// active-low serial streams. Optional macro SNAC_UNPLUG_DETECT_EN adds pad-absent flags.
module snac_poll_scheduler #(
   parameter int MASTER_CLK_FREQ = 96_000_000,
   parameter int BIT_RATE_HZ     = 100_000,
   parameter int NUM_BITS        = 16
) (
   input  logic       clk_sys,
   input  logic       reset_l_main,
   input  logic       i_ena,
   input  logic [2:0] sample_rate,
   input  logic       start_now,
   input  logic       snac_d1,
   input  logic       snac_d2,
   output logic       snac_latch,
   output logic       snac_clk,
   output logic [2:0] dbg_state,
   snac_poll_scheduler_if.master btn_bus
);

   localparam int HALF     = MASTER_CLK_FREQ / (2 * BIT_RATE_HZ);
   localparam int TICKS_US = MASTER_CLK_FREQ / 1_000_000;
   localparam int IVL_MAX  = TICKS_US * 16000;
   localparam int IVL_W    = $clog2(IVL_MAX + 1);
   localparam int PH_W     = $clog2(2 * HALF);
   localparam int BIT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LATCH    = 3'd1,
      S_GAP      = 3'd2,
      S_SHIFT_LO = 3'd3,
      S_SHIFT_HI = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [PH_W-1:0]      ph_q, ph_d, dur_m1;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic                 cap;
   logic                 ph_last;

   logic [1:0]           d1_sync, d2_sync;
   logic                 d1_s, d2_s;

   logic [IVL_W-1:0]     ivl_cnt, reload_val;
   logic                 expire, start_ok, pending_q, in_frame;

   logic [NUM_BITS-1:0]  shreg1, shreg2, raw1_full, raw2_full;
   logic [NUM_BITS-1:0]  btn1_new, btn2_new;
   logic [NUM_BITS-1:0]  p1_q, p2_q;
   logic                 latch_q, sclk_q, busy_q, stb_q;
   logic                 done_load;

   // Pad data lines are asynchronous to clk_sys.
   always_ff @(posedge clk_sys or negedge reset_l_main) begin
      if (!reset_l_main) begin
         d1_sync <= 2'b11;
         d2_sync <= 2'b11;
      end else begin
         d1_sync <= {d1_sync[0], snac_d1};
         d2_sync <= {d2_sync[0], snac_d2};
      end
   end

   assign d1_s = d1_sync[1];
   assign d2_s = d2_sync[1];

   always_comb begin
      case (sample_rate)
         3'd0:    reload_val = IVL_W'(TICKS_US * 16000 - 1);
         3'd1:    reload_val = IVL_W'(TICKS_US * 4000 - 1);
         3'd2:    reload_val = IVL_W'(TICKS_US * 1000 - 1);
         default: reload_val = IVL_W'(TICKS_US * 500 - 1);
      endcase
   end

   assign expire   = i_ena && (ivl_cnt == '0);
   assign start_ok = i_ena && start_now && (state_q == S_IDLE);
   assign in_frame = (state_q != S_IDLE) && (state_q != S_DONE);

   // Reload with the interval minus one so expiries are exactly one interval apart.
   always_ff @(posedge clk_sys or negedge reset_l_main) begin
      if (!reset_l_main) begin
         ivl_cnt <= '0;
      end else if (!i_ena) begin
         ivl_cnt <= '0;
      end else if (expire || start_ok) begin
         ivl_cnt <= reload_val;
      end else begin
         ivl_cnt <= ivl_cnt - IVL_W'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_l_main) begin
      if (!reset_l_main) begin
         pending_q <= 1'b0;
      end else if (!i_ena) begin
         pending_q <= 1'b0;
      end else if (expire && in_frame) begin
         pending_q <= 1'b1;
      end else if (state_q == S_DONE) begin
         pending_q <= 1'b0;
      end
   end

   assign dur_m1  = (state_q == S_LATCH) ? PH_W'(2 * HALF - 1) : PH_W'(HALF - 1);
   assign ph_last = (ph_q == dur_m1);

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q + PH_W'(1);
      bit_d   = bit_q;
      cap     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (expire || pending_q || start_ok) begin
               state_d = S_LATCH;
               bit_d   = '0;
            end
         end
         S_LATCH: begin
            if (ph_last) state_d = S_GAP;
         end
         S_GAP: begin
            if (ph_last) begin
               cap     = 1'b1;
               bit_d   = BIT_W'(1);
               state_d = S_SHIFT_LO;
            end
         end
         S_SHIFT_LO: begin
            if (ph_last) state_d = S_SHIFT_HI;
         end
         S_SHIFT_HI: begin
            if (ph_last) begin
               cap = 1'b1;
               if (bit_q == BIT_W'(NUM_BITS - 1)) begin
                  state_d = S_DONE;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  state_d = S_SHIFT_LO;
               end
            end
         end
         S_DONE: begin
            // A request that arrived during the frame starts the next one back-to-back.
            if (expire || pending_q) begin
               state_d = S_LATCH;
               bit_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (!i_ena) begin
         state_d = S_IDLE;
         cap     = 1'b0;
      end
      if (state_d != state_q) ph_d = '0;
   end

   always_ff @(posedge clk_sys or negedge reset_l_main) begin
      if (!reset_l_main) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
      end
   end

   assign dbg_state = state_q;

   always_comb begin
      raw1_full        = shreg1;
      raw2_full        = shreg2;
      raw1_full[bit_q] = d1_s;
      raw2_full[bit_q] = d2_s;
   end

   always_ff @(posedge clk_sys or negedge reset_l_main) begin
      if (!reset_l_main) begin
         shreg1 <= '0;
         shreg2 <= '0;
      end else if (cap) begin
         shreg1[bit_q] <= d1_s;
         shreg2[bit_q] <= d2_s;
      end
   end

   assign done_load = (state_d == S_DONE);

`ifdef SNAC_UNPLUG_DETECT_EN
   // An all-low raw word means the line is pulled down with no pad attached.
   logic p1_abs_q, p2_abs_q;

   always_comb begin
      btn1_new = (raw1_full == '0) ? '0 : ~raw1_full;
      btn2_new = (raw2_full == '0) ? '0 : ~raw2_full;
   end

   always_ff @(posedge clk_sys or negedge reset_l_main) begin
      if (!reset_l_main) begin
         p1_abs_q <= 1'b0;
         p2_abs_q <= 1'b0;
      end else if (done_load) begin
         p1_abs_q <= (raw1_full == '0);
         p2_abs_q <= (raw2_full == '0);
      end
   end

   assign btn_bus.p1_absent = p1_abs_q;
   assign btn_bus.p2_absent = p2_abs_q;
`else
   always_comb begin
      btn1_new = ~raw1_full;
      btn2_new = ~raw2_full;
   end

   assign btn_bus.p1_absent = 1'b0;
   assign btn_bus.p2_absent = 1'b0;
`endif

   // Pad-facing and status outputs are registered from the next state so they
   // line up with state_q and never glitch.
   always_ff @(posedge clk_sys or negedge reset_l_main) begin
      if (!reset_l_main) begin
         latch_q <= 1'b0;
         sclk_q  <= 1'b1;
         busy_q  <= 1'b0;
         stb_q   <= 1'b0;
         p1_q    <= '0;
         p2_q    <= '0;
      end else begin
         latch_q <= (state_d == S_LATCH);
         sclk_q  <= (state_d != S_SHIFT_LO);
         busy_q  <= (state_d != S_IDLE);
         stb_q   <= done_load;
         if (done_load) begin
            p1_q <= btn1_new;
            p2_q <= btn2_new;
         end
      end
   end

   assign snac_latch     = latch_q;
   assign snac_clk       = sclk_q;
   assign btn_bus.busy   = busy_q;
   assign btn_bus.o_stb  = stb_q;
   assign btn_bus.p1_btn = p1_q;
   assign btn_bus.p2_btn = p2_q;

endmodule

// File: tb/tb_snac_poll_scheduler.sv
// Bench for snac_poll_scheduler: behavioural SNES-style pad model, scoreboard of
// expected button words, and waveform/interval checks at reduced clock rates.
module tb_snac_poll_scheduler;

   localparam int MCF   = 1_000_000;
   localparam int BR    = 31_250;
   localparam int NB    = 16;
   localparam int H     = MCF / (2 * BR);
   localparam int TUS   = MCF / 1_000_000;
   localparam int FRAME = 33 * H;
`ifdef SNAC_UNPLUG_DETECT_EN
   localparam logic [15:0] UNPLUG_BTN = 16'h0000;
`else
   localparam logic [15:0] UNPLUG_BTN = 16'hFFFF;
`endif

   logic       clk_sys = 1'b0;
   logic       reset_l_main = 1'b0;
   logic       i_ena = 1'b1;
   logic [2:0] sample_rate = 3'd2;
   logic       start_now = 1'b0;
   logic       snac_d1, snac_d2;
   logic       snac_latch, snac_clk;
   logic [2:0] dbg_state;

   snac_poll_scheduler_if #(.NUM_BITS(NB)) bus ();

   snac_poll_scheduler #(
      .MASTER_CLK_FREQ(MCF),
      .BIT_RATE_HZ    (BR),
      .NUM_BITS       (NB)
   ) dut (
      .clk_sys     (clk_sys),
      .reset_l_main(reset_l_main),
      .i_ena       (i_ena),
      .sample_rate (sample_rate),
      .start_now   (start_now),
      .snac_d1     (snac_d1),
      .snac_d2     (snac_d2),
      .snac_latch  (snac_latch),
      .snac_clk    (snac_clk),
      .dbg_state   (dbg_state),
      .btn_bus     (bus.master)
   );

   // ---------------- clock ----------------
   always #5 clk_sys = ~clk_sys;

   // ---------------- checking core ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [33:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int ivl(input int rate);
      case (rate)
         0:       return TUS * 16000;
         1:       return TUS * 4000;
         2:       return TUS * 1000;
         default: return TUS * 500;
      endcase
   endfunction

   // Expected {p1_absent, p2_absent, p1_btn, p2_btn} from the raw serial words.
   function automatic logic [33:0] model(input logic [15:0] r1, input logic [15:0] r2);
      logic a1, a2;
      logic [15:0] b1, b2;
`ifdef SNAC_UNPLUG_DETECT_EN
      a1 = (r1 == 16'h0000);
      a2 = (r2 == 16'h0000);
      b1 = a1 ? 16'h0000 : ~r1;
      b2 = a2 ? 16'h0000 : ~r2;
`else
      a1 = 1'b0;
      a2 = 1'b0;
      b1 = ~r1;
      b2 = ~r2;
`endif
      return {a1, a2, b1, b2};
   endfunction

   function automatic logic [15:0] gen_word();
      if ($urandom_range(0, 3) == 0) return 16'h0000;
      return 16'($urandom());
   endfunction

   // ---------------- pad model ----------------
   // Latch loads the word and presents bit 0; each rising shift-clock edge
   // presents the next bit; past the last bit the line reads high.
   logic [15:0] nxt_p1 = 16'hFFFF, nxt_p2 = 16'hFFFF;
   logic [15:0] cur_p1 = 16'hFFFF, cur_p2 = 16'hFFFF;
   bit          rand_mode = 1'b0;
   int          pad_idx = NB;

   always @(posedge snac_latch or posedge snac_clk) begin
      if (snac_latch) begin
         if (rand_mode) begin
            cur_p1 = gen_word();
            cur_p2 = gen_word();
         end else begin
            cur_p1 = nxt_p1;
            cur_p2 = nxt_p2;
         end
         pad_idx = 0;
         exp_q.push_back(model(cur_p1, cur_p2));
      end else if (pad_idx < NB) begin
         pad_idx++;
      end
   end

   assign snac_d1 = (pad_idx < NB) ? cur_p1[pad_idx] : 1'b1;
   assign snac_d2 = (pad_idx < NB) ? cur_p2[pad_idx] : 1'b1;

   // ---------------- monitor / scoreboard ----------------
   int cyc = 0, n_rise = 0, rise_cyc = 0, rise_gap = 0, n_stb = 0;
   int latch_len = 0, lo_len = 0, low_cnt = 0, bad_w = 0;
   logic prev_latch = 1'b0, prev_sclk = 1'b1, prev_stb = 1'b0;
   logic [15:0] last_p1 = 16'h0000, last_p2 = 16'h0000;

   always @(negedge clk_sys) begin
      logic [33:0] e;
      cyc++;
      if (!reset_l_main) begin
         prev_latch = 1'b0;
         prev_sclk  = 1'b1;
         prev_stb   = 1'b0;
         last_p1    = 16'h0000;
         last_p2    = 16'h0000;
      end else begin
         if (snac_latch && !prev_latch) begin
            rise_gap  = cyc - rise_cyc;
            rise_cyc  = cyc;
            n_rise++;
            latch_len = 0;
            lo_len    = 0;
            low_cnt   = 0;
            bad_w     = 0;
         end
         if (snac_latch) latch_len++;
         if (!snac_clk) begin
            lo_len++;
         end else if (!prev_sclk) begin
            low_cnt++;
            if (lo_len != H) bad_w++;
            lo_len = 0;
         end
         if (bus.o_stb) begin
            n_stb++;
            check("stb_width", 32'(prev_stb), 32'd0);
            check("busy_at_stb", 32'(bus.busy), 32'd1);
            check("frame_len", cyc - rise_cyc, FRAME);
            check("latch_len", latch_len, 2 * H);
            check("clk_pulses", low_cnt, 15);
            check("clk_width_errs", bad_w, 0);
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("p1_btn", 32'(bus.p1_btn), 32'(e[31:16]));
               check("p2_btn", 32'(bus.p2_btn), 32'(e[15:0]));
               check("p1_absent", 32'(bus.p1_absent), 32'(e[33]));
               check("p2_absent", 32'(bus.p2_absent), 32'(e[32]));
               last_p1 = e[31:16];
               last_p2 = e[15:0];
            end
         end
         prev_latch = snac_latch;
         prev_sclk  = snac_clk;
         prev_stb   = bus.o_stb;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic wait_rise(input string tag, input int budget);
      int start, t;
      start = n_rise;
      t = 0;
      while (n_rise == start && t < budget) begin
         tick();
         t++;
      end
      check(tag, 32'(n_rise != start), 32'd1);
   endtask

   task automatic wait_stb(input string tag, input int budget);
      int start, t;
      start = n_stb;
      t = 0;
      while (n_stb == start && t < budget) begin
         tick();
         t++;
      end
      check(tag, 32'(n_stb != start), 32'd1);
   endtask

   task automatic check_idle_pads(input string tag);
      check({tag, "_latch"}, 32'(snac_latch), 32'd0);
      check({tag, "_sclk"}, 32'(snac_clk), 32'd1);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_idle_pads(tag);
      check({tag, "_stb"}, 32'(bus.o_stb), 32'd0);
      check({tag, "_p1"}, 32'(bus.p1_btn), 32'd0);
      check({tag, "_p2"}, 32'(bus.p2_btn), 32'd0);
      check({tag, "_abs1"}, 32'(bus.p1_absent), 32'd0);
      check({tag, "_abs2"}, 32'(bus.p2_absent), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int stb0;
      nxt_p1 = 16'hFFFE;
      nxt_p2 = 16'h5AF0;
      repeat (3) tick();
      check_reset_vals("reset");

      // First frame fires on the first enabled cycle after reset.
      reset_l_main = 1'b1;
      tick();
      check("first_latch", 32'(snac_latch), 32'd1);
      check("first_busy", 32'(bus.busy), 32'd1);
      wait_stb("first_stb", FRAME + 10);
      check("first_p1_direct", 32'(bus.p1_btn), 32'h0001);
      check("first_p2_direct", 32'(bus.p2_btn), 32'hA50F);
      tick();
      check_idle_pads("after_first");

      rand_mode = 1'b1;
      wait_rise("rise_r2", ivl(2) + 100);
      check("gap_rate2", rise_gap, ivl(2));

      // Rate change mid-interval applies only at the next reload.
      repeat (600) tick();
      sample_rate = 3'd3;
      wait_rise("rise_chg", ivl(2) + 100);
      check("gap_after_change", rise_gap, ivl(2));
      wait_rise("rise_pend1", 2 * FRAME);
      check("gap_pending1", rise_gap, FRAME + 1);
      wait_rise("rise_pend2", 2 * FRAME);
      check("gap_pending2", rise_gap, FRAME + 1);

      sample_rate = 3'd1;
      wait_rise("rise_r1a", ivl(1) + 100);
      wait_rise("rise_r1b", ivl(1) + 100);
      wait_rise("rise_r1c", ivl(1) + 100);
      check("gap_rate1", rise_gap, ivl(1));

      sample_rate = 3'd0;
      wait_rise("rise_r0a", ivl(1) + 100);
      check("gap_r1_before_r0", rise_gap, ivl(1));
      wait_rise("rise_r0b", ivl(0) + 100);
      check("gap_rate0", rise_gap, ivl(0));

      // start_now in IDLE launches at once and restarts the interval.
      sample_rate = 3'd2;
      wait_stb("stb_r0", FRAME + 10);
      repeat (100) tick();
      check("idle_before_start", 32'(snac_latch), 32'd0);
      stb0 = n_stb;
      start_now = 1'b1;
      tick();
      start_now = 1'b0;
      check("start_latch", 32'(snac_latch), 32'd1);
      check("start_busy", 32'(bus.busy), 32'd1);
      repeat (199) tick();
      start_now = 1'b1;
      tick();
      start_now = 1'b0;
      wait_rise("rise_after_start", ivl(2) + 100);
      check("gap_start_restart", rise_gap, ivl(2));
      check("one_stb_per_start", n_stb - stb0, 1);

      // Disable after bit 7 has been sampled.
      repeat (17 * H + 4) tick();
      i_ena = 1'b0;
      tick();
      check_idle_pads("abort");
      check("abort_p1_hold", 32'(bus.p1_btn), 32'(last_p1));
      check("abort_p2_hold", 32'(bus.p2_btn), 32'(last_p2));
      exp_q.delete();
      stb0 = n_stb;
      repeat (40) tick();
      check("abort_no_stb", n_stb - stb0, 0);
      check_idle_pads("disabled");
      i_ena = 1'b1;
      tick();
      check("reenable_latch", 32'(snac_latch), 32'd1);
      wait_stb("stb_reenable", FRAME + 10);

      // Unplugged pad (all lines low), then replugged with nothing pressed.
      rand_mode = 1'b0;
      nxt_p1 = 16'h0000;
      nxt_p2 = 16'h1234;
      wait_rise("rise_unplug", ivl(2) + 100);
      nxt_p1 = 16'hFFFF;
      wait_stb("stb_unplug", FRAME + 10);
      check("unplug_p1_btn", 32'(bus.p1_btn), 32'(UNPLUG_BTN));
      wait_rise("rise_replug", ivl(2) + 100);
      wait_stb("stb_replug", FRAME + 10);
      check("replug_p1_btn", 32'(bus.p1_btn), 32'h0000);
      check("replug_p1_abs", 32'(bus.p1_absent), 32'd0);

      // Asynchronous reset in the middle of a frame.
      rand_mode = 1'b1;
      wait_rise("rise_before_rst", ivl(2) + 100);
      repeat (264) tick();
      @(posedge clk_sys);
      #3;
      reset_l_main = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      exp_q.delete();
      tick();
      reset_l_main = 1'b1;
      tick();
      check("post_reset_latch", 32'(snac_latch), 32'd1);
      wait_stb("post_reset_stb", FRAME + 10);

      // Random words with back-to-back frames.
      sample_rate = 3'd3;
      for (int i = 0; i < 20; i++) wait_stb("rand_stb", 3 * FRAME);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
